// File: rtl/regfile.sv
// regfile: 31 x WIDTH-bit register file with a hardwired zero register at
// index NREGS-1 (X31), one write port, and two combinational read ports.
// A read of the register being written in the same cycle sees the incoming
// data, so a consumer never observes a stale value.
module regfile #(
    parameter int WIDTH = 64,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    // Index of the zero register; it has no storage behind it.
    localparam logic [4:0] ZERO_IDX = 5'(NREGS - 1);

    logic [WIDTH-1:0] regs [0:NREGS-2];
    logic [NREGS-2:0] wen;

    // Write decoder: one-hot enable, at most one bit set, none for X31.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
        wen = '0;
        for (int i = 0; i < NREGS - 1; i++) begin
            wen[i] = RegWrite && (WriteRegister == 5'(i));
        end
    end

    // Storage: async clear, otherwise each register picks between hold and WriteData.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the array is cleared on reset, so it maps to flops rather than an SRAM macro; that is intended here.
            for (int i = 0; i < NREGS - 1; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge state.
            for (int i = 0; i < NREGS - 1; i++) begin
                regs[i] <= wen[i] ? WriteData : regs[i];
            end
        end
    end

    // Read port 1: zero in reset or for X31, bypass on a same-cycle write, else storage.
    always_comb begin
        ReadData1 = '0;
        if (reset_n && (ReadRegister1 < ZERO_IDX)) begin
            if (RegWrite && (WriteRegister == ReadRegister1)) begin
                ReadData1 = WriteData;
            end else begin
                ReadData1 = regs[ReadRegister1];
            end
        end
    end

    // Read port 2: identical to port 1, fully independent.
    always_comb begin
        ReadData2 = '0;
        if (reset_n && (ReadRegister2 < ZERO_IDX)) begin
            if (RegWrite && (WriteRegister == ReadRegister2)) begin
                ReadData2 = WriteData;
            end else begin
                ReadData2 = regs[ReadRegister2];
            end
        end
    end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed, table-driven bench for regfile. Inputs are driven on
// the falling edge and outputs sampled 1 time unit later, well clear of the
// rising edge that commits writes.
module tb_regfile;

    logic        clk;
    logic        reset_n;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int checks;
    int errors;

    regfile #(.WIDTH(64), .NREGS(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .RegWrite     (RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [63:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [63:0] e1;
        logic [63:0] e2;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wr, input logic [63:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        RegWrite      = we;
        WriteRegister = wr;
        WriteData     = wd;
        ReadRegister1 = r1;
        ReadRegister2 = r2;
    endtask

    // Expected stored value after the fill loop: X_i = i, X31 = 0.
    function automatic logic [63:0] fill_val(input int idx);
        return (idx == 31) ? 64'd0 : 64'(idx);
    endfunction

    initial begin
        checks = 0;
        errors = 0;

        // Each row: inputs applied before the edge; e1/e2 are the expected
        // read data in that same cycle (bypass included).
        vecs[0]  = '{1'b1, 5'd5,  64'hDEAD_BEEF_0123_4567, 5'd5,  5'd5,  64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567};
        vecs[1]  = '{1'b0, 5'd0,  64'h0,                   5'd5,  5'd5,  64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567};
        vecs[2]  = '{1'b0, 5'd0,  64'h0,                   5'd4,  5'd6,  64'h0,                   64'h0};
        vecs[3]  = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd5,  64'h0,                   64'hDEAD_BEEF_0123_4567};
        vecs[4]  = '{1'b0, 5'd0,  64'h0,                   5'd31, 5'd31, 64'h0,                   64'h0};
        vecs[5]  = '{1'b0, 5'd7,  64'h1234,                5'd7,  5'd7,  64'h0,                   64'h0};
        vecs[6]  = '{1'b0, 5'd0,  64'h0,                   5'd7,  5'd5,  64'h0,                   64'hDEAD_BEEF_0123_4567};
        vecs[7]  = '{1'b1, 5'd3,  64'hA5A5,                5'd3,  5'd0,  64'hA5A5,                64'h0};
        vecs[8]  = '{1'b0, 5'd0,  64'h0,                   5'd3,  5'd3,  64'hA5A5,                64'hA5A5};
        vecs[9]  = '{1'b1, 5'd0,  64'h1111,                5'd0,  5'd30, 64'h1111,                64'h0};
        vecs[10] = '{1'b1, 5'd30, 64'h3030,                5'd0,  5'd30, 64'h1111,                64'h3030};
        vecs[11] = '{1'b1, 5'd5,  64'h5555,                5'd5,  5'd3,  64'h5555,                64'hA5A5};
        vecs[12] = '{1'b0, 5'd0,  64'h0,                   5'd5,  5'd30, 64'h5555,                64'h3030};
        vecs[13] = '{1'b0, 5'd0,  64'h0,                   5'd31, 5'd0,  64'h0,                   64'h1111};

        // Reset held: a write attempt across an edge is ignored and the bypass is suppressed.
        reset_n = 1'b0;
        drive(1'b1, 5'd4, 64'hCAFE, 5'd4, 5'd4);
        @(negedge clk);
        @(negedge clk);
        check("reset_bypass_rd1", ReadData1, 64'h0);
        check("reset_bypass_rd2", ReadData2, 64'h0);

        // Release away from the edge, then every index on both ports reads 0.
        drive(1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
        #2 reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            #1;
            check($sformatf("post_reset_rd1_x%0d", i), ReadData1, 64'h0);
            check($sformatf("post_reset_rd2_x%0d", 31 - i), ReadData2, 64'h0);
        end

        // Table-driven vectors, one rising edge per row.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].wr, vecs[i].wd, vecs[i].r1, vecs[i].r2);
            #1;
            check($sformatf("vec%0d_rd1", i), ReadData1, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), ReadData2, vecs[i].e2);
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 64'h0, 5'd0, 5'd0);

        // Fill X0..X30 with their own index, then read everything back.
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            drive(1'b1, 5'(i), 64'(i), 5'd31, 5'd31);
        end
        @(negedge clk);
        RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            #1;
            check($sformatf("fill_rd1_x%0d", i), ReadData1, fill_val(i));
            check($sformatf("fill_rd2_x%0d", 31 - i), ReadData2, fill_val(31 - i));
        end

        // Drop reset mid-cycle with no clock edge: contents clear immediately.
        @(negedge clk);
        #2 reset_n = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            #1;
            check($sformatf("async_clr_rd1_x%0d", i), ReadData1, 64'h0);
            check($sformatf("async_clr_rd2_x%0d", 31 - i), ReadData2, 64'h0);
        end

        // Write attempt to X2 across a rising edge while reset is asserted.
        @(negedge clk);
        drive(1'b1, 5'd2, 64'h77, 5'd2, 5'd2);
        @(negedge clk);
        check("reset_write_rd1", ReadData1, 64'h0);
        RegWrite = 1'b0;
        #2 reset_n = 1'b1;
        #1;
        check("reset_write_after_release", ReadData1, 64'h0);

        // First write after release behaves normally.
        @(negedge clk);
        drive(1'b1, 5'd2, 64'd9, 5'd2, 5'd3);
        #1;
        check("rel_write_bypass", ReadData1, 64'd9);
        check("rel_other_zero", ReadData2, 64'h0);
        @(negedge clk);
        drive(1'b0, 5'd0, 64'h0, 5'd2, 5'd2);
        #1;
        check("rel_write_rd1", ReadData1, 64'd9);
        check("rel_write_rd2", ReadData2, 64'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter WIDTH, default 64, data width of each register in bits.
REQ-002 Parameter NREGS, default 32, number of architectural registers; index NREGS-1 (X31) is the zero register.
REQ-003 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 RegWrite  input  1  write enable for the write port.
REQ-007 WriteRegister  input  5  write-port register index.
REQ-008 WriteData  input  WIDTH  write-port data.
REQ-009 ReadRegister1  input  5  read-port-1 register index.
REQ-010 ReadRegister2  input  5  read-port-2 register index.
REQ-011 ReadData1  output  WIDTH  read-port-1 data, combinational.
REQ-012 ReadData2  output  WIDTH  read-port-2 data, combinational.

Function
REQ-013 Storage SHALL be NREGS-1 registers (X0..X30) of WIDTH bits each; X31 SHALL have no storage.
REQ-014 Write decode SHALL be a 5-to-32 decoder gated by RegWrite, giving one-hot enable to at most one register per cycle.
REQ-015 On rising clk with RegWrite=1 and WriteRegister<31, register[WriteRegister] SHALL load WriteData; all other registers SHALL hold.
REQ-016 RegWrite=1 with WriteRegister=31 SHALL be discarded with no state change.
REQ-017 RegWrite=0 SHALL leave all registers unchanged regardless of WriteRegister/WriteData.
REQ-018 Each register bit SHALL hold via a 2:1 select between its current value and WriteData, controlled by its decoder enable.
REQ-019 ReadDataN SHALL equal register[ReadRegisterN] combinationally, with no clock latency.
REQ-020 ReadRegisterN=31 SHALL give ReadDataN=0 at all times.
REQ-021 Bypass: if RegWrite=1, WriteRegister=ReadRegisterN and WriteRegister<31, ReadDataN SHALL equal WriteData in the same cycle, before the edge.
REQ-022 Both read ports SHALL be independent; equal indices on both ports SHALL return identical data.
REQ-023 A write and a read of the same register in one cycle SHALL commit the write at the edge; the bypassed value and the post-edge stored value SHALL match.
REQ-024 Index arithmetic is unsigned 5-bit; no index wraps or aliases.

Reset
REQ-025 reset_n=0 SHALL clear X0..X30 to 0 immediately, independent of clk.
REQ-026 While reset_n=0, writes SHALL be ignored and ReadData1/ReadData2 SHALL read 0 for every index.
REQ-027 Reset asserted mid-write (in the same cycle as a RegWrite edge) SHALL leave the target register at 0.
REQ-028 After reset_n deasserts, the first rising clk with RegWrite=1 SHALL perform a normal write.

Verification
REQ-029 Reset then read all 32 indices on both ports -> every read returns 0.
REQ-030 Write X5=64'hDEAD_BEEF_0123_4567, next cycle read port 1 index 5 and port 2 index 5 -> both return 64'hDEAD_BEEF_0123_4567; all other registers remain 0.
REQ-031 RegWrite=1, WriteRegister=31, WriteData=64'hFFFF_FFFF_FFFF_FFFF, then read index 31 -> returns 0.
REQ-032 RegWrite=0, WriteRegister=7, WriteData=64'h1234, edge, read index 7 -> returns prior value 0.
REQ-033 Same cycle: RegWrite=1, WriteRegister=3, WriteData=64'hA5A5, ReadRegister1=3 -> ReadData1=64'hA5A5 before the edge, and it is still 64'hA5A5 after the edge with RegWrite=0.
REQ-034 Write X0..X30 with value=index, drop reset_n low mid-cycle without a clk edge -> all reads return 0 immediately; after release, write X2=9 -> reads 9.
